// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson counter with direction, enable, load, 1-injection, wrap and err.
// Define RING_SELF_CORRECT_EN to force y back to HOME when an illegal state is shifted.
module ring_counter_param #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             inj,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] y,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] y_q, y_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] y_inv;
  logic [WIDTH-1:0] shifted;
  logic             fb;
  logic             ring_ok;
  logic             john_ok;

  always_comb begin
    home  = mode ? '0 : RST_VAL;
    y_inv = ~y_q;
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    ring_ok = (y_q != '0) && ((y_q & (y_q - One)) == '0);
    // Johnson legal set: ones packed at the bottom, or zeros packed at the bottom.
    john_ok = ((y_q & (y_q + One)) == '0) || ((y_inv & (y_inv + One)) == '0);
    err     = mode ? ~john_ok : ~ring_ok;
  end

  always_comb begin
    if (dir) begin
      fb      = inj | (y_q[WIDTH-1] ^ mode);
      shifted = {y_q[WIDTH-2:0], fb};
    end else begin
      fb      = inj | (y_q[0] ^ mode);
      shifted = {fb, y_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    y_d    = y_q;
    wrap_d = 1'b0;
    if (load) begin
      y_d = load_val;
    end else if (en) begin
`ifdef RING_SELF_CORRECT_EN
      if (err) begin
        y_d    = home;
        wrap_d = 1'b1;
      end else begin
        y_d    = shifted;
        wrap_d = (shifted == home);
      end
`else
      y_d    = shifted;
      wrap_d = (shifted == home);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q    <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      wrap_q <= wrap_d;
    end
  end

  assign y    = y_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_counter_param.sv
// Scoreboard bench for ring_counter_param: driver pushes model expectations, monitor pops and compares.
// Honours RING_SELF_CORRECT_EN in the reference model.
module tb_ring_counter_param;

  localparam int unsigned W = 4;
  localparam logic [W-1:0] RstVal = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, mode = 1'b0, dir = 1'b0, inj = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] y;
  logic         wrap, err;

  ring_counter_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .inj(inj),
    .load(load), .load_val(load_val), .y(y), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    logic         wrap;
    logic         err;
    string        tag;
  } exp_t;

  exp_t         q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] m_y = RstVal;
  bit           m_wrap = 1'b0;

  // Legal patterns listed outright: one-hot for ring; k ones at the bottom or top for Johnson.
  function automatic bit legal(bit md, logic [W-1:0] v);
    logic [W-1:0] low;
    if (!md) return $countones(v) == 1;
    for (int k = 0; k <= W; k++) begin
      low = W'((1 << k) - 1);
      if (v == low || v == ~low) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] home_of(bit md);
    return md ? '0 : RstVal;
  endfunction

  task automatic push(input string tag);
    exp_t e;
    e.y = m_y; e.wrap = m_wrap; e.err = !legal(mode, m_y); e.tag = tag;
    q.push_back(e);
  endtask

  task automatic model_edge();
    bit out, fb;
    if (load) begin
      m_y = load_val; m_wrap = 1'b0;
    end else if (en) begin
`ifdef RING_SELF_CORRECT_EN
      if (!legal(mode, m_y)) begin
        m_y = home_of(mode); m_wrap = 1'b1;
        return;
      end
`endif
      out = dir ? m_y[W-1] : m_y[0];
      fb  = inj ? 1'b1 : (mode ? !out : out);
      if (!dir) m_y = (m_y >> 1) | (W'(fb) << (W - 1));
      else      m_y = (m_y << 1) | W'(fb);
      m_wrap = (m_y == home_of(mode));
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  task automatic step(input bit e, input bit m, input bit d, input bit i, input bit l,
                      input logic [W-1:0] lv, input string tag);
    @(negedge clk);
    rst = 1'b1; en = e; mode = m; dir = d; inj = i; load = l; load_val = lv;
    model_edge();
    push(tag);
  endtask

  task automatic hold_reset(input string tag);
    @(negedge clk);
    rst = 1'b0; en = 1'b0; load = 1'b0; inj = 1'b0;
    m_y = RstVal; m_wrap = 1'b0;
    push(tag);
  endtask

  // Reset asserted between edges: one check right after assertion, one at the edge in reset.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    en = 1'b1; load = 1'b0; inj = 1'b0; dir = 1'b0;
    #2 rst = 1'b0;
    m_y = RstVal; m_wrap = 1'b0;
    push({tag, "_async"});
    push({tag, "_held"});
  endtask

  // Monitor: outputs are presented after every clock edge and every reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (y !== e.y || wrap !== e.wrap || err !== e.err) begin
          n_bad++;
          $display("FAIL %s: got y=%b wrap=%b err=%b, expected y=%b wrap=%b err=%b",
                   e.tag, y, wrap, err, e.y, e.wrap, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit rm;
    hold_reset("reset_state");
    // Ring, right shift straight out of reset.
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, '0, "ring_right");
    // Johnson from all-zeros, 8-step period.
    step(0, 1, 0, 0, 1, 4'b0000, "john_load");
    for (int k = 0; k < 8; k++) step(1, 1, 0, 0, 0, '0, "john_right");
    // Ring, left shift.
    step(0, 0, 1, 0, 1, 4'b1000, "ring_load");
    for (int k = 0; k < 4; k++) step(1, 0, 1, 0, 0, '0, "ring_left");
    // Illegal ring state.
    step(0, 0, 0, 0, 1, 4'b0110, "illegal_load");
    step(1, 0, 0, 0, 0, '0, "illegal_shift");
    // Injection, then load overriding injection.
    step(0, 0, 0, 0, 1, 4'b0100, "inj_load");
    step(1, 0, 0, 1, 0, '0, "inj_shift");
    step(1, 0, 0, 1, 1, 4'b0001, "load_over_inj");
    // Async reset mid-cycle, en held through release.
    step(0, 0, 0, 0, 1, 4'b0010, "pre_reset_load");
    mid_reset("mid_reset");
    step(1, 0, 0, 0, 0, '0, "post_reset_shift");
    // Randomised phase.
    rm = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) rm = !rm;
      if ($urandom_range(0, 63) == 0) begin
        mode = rm;
        mid_reset("rand_reset");
      end else begin
        step($urandom_range(0, 3) != 0, rm, 1'($urandom_range(0, 1)),
             $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
             W'($urandom_range(0, (1 << W) - 1)), "random");
      end
    end
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    cyc = 0;
    while (q.size() > 0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
